// File: rtl/bus_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_receiver_if
// Description : Bundles the master bus input and the command stream between
//               the external master / consumer and bus_receiver.
//               master modport: drives master_bus and cmd_ready, observes
//                               the command stream and status.
//               slave modport : bus_receiver side.
//               Signals: master_bus[23:0] (strobe, meta, data), cmd_meta[4:0],
//               cmd_data[17:0], cmd_valid, cmd_ready, soft_rst, overflow,
//               fifo_level[$clog2(FIFO_DEPTH):0].
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_receiver_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [23:0]   master_bus;
    logic [4:0]    cmd_meta;
    logic [17:0]   cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          soft_rst;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    modport master (
        output master_bus, cmd_ready,
        input  cmd_meta, cmd_data, cmd_valid, soft_rst, overflow, fifo_level
    );

    modport slave (
        input  master_bus, cmd_ready,
        output cmd_meta, cmd_data, cmd_valid, soft_rst, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/bus_receiver.sv
`default_nettype none
// ============================================================================
// Module      : bus_receiver
// Description : Synchronizes the asynchronous master strobe, captures the
//               meta/data word on each strobe rise, absorbs NOOP words,
//               flushes on RST words (with a one-cycle soft_rst pulse) and
//               queues all other words in a FIFO presented as a valid/ready
//               command stream.
//               Ports: clk    - system clock (rising edge)
//                      rst_n  - asynchronous active-low reset
//                      bus    - bus_receiver_if.slave (master_bus in,
//                               cmd_* stream, soft_rst, overflow, fifo_level)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_receiver #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bus_receiver_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [4:0] C_META_NOOP = 5'b00000;
    localparam logic [4:0] C_META_RST  = 5'b11111;
    localparam logic [LW-1:0] C_FULL_LEVEL = LW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Strobe synchronizer, edge detector and data capture
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    // Tracks which synchronizer stages hold a genuine sample since reset;
    // the reset value of sync_q must not count as "strobe seen low".
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;
    logic [22:0]            bus_q;

    logic w_sync_out;
    assign w_sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            bus_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.master_bus[23]};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= w_sync_out;
            if (fill_q[SYNC_STAGES-1] && !w_sync_out) begin
                armed_q <= 1'b1;
            end
            bus_q <= bus.master_bus[22:0];
        end
    end

    logic       w_rise;
    logic [4:0] w_meta;
    logic       w_is_noop;
    logic       w_is_rst;

    assign w_rise    = w_sync_out & ~prev_q & armed_q;
    assign w_meta    = bus_q[22:18];
    assign w_is_noop = (w_meta == C_META_NOOP);
    assign w_is_rst  = (w_meta == C_META_RST);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [22:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          soft_q, soft_d;

    logic w_flush, w_push_req, w_pop, w_full, w_push;

    assign w_flush    = w_rise & w_is_rst;
    assign w_push_req = w_rise & ~w_is_noop & ~w_is_rst;
    assign w_pop      = valid_q & bus.cmd_ready;
    assign w_full     = (level_q == C_FULL_LEVEL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req & (~w_full | w_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        soft_d  = 1'b0;
        if (w_flush) begin
            // Flush takes priority over any concurrent pop.
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            soft_d  = 1'b1;
        end else begin
            if (w_push) begin
                wr_d = wr_q + AW'(1);
            end
            if (w_pop) begin
                rd_d = rd_q + AW'(1);
            end
            level_d = level_q + LW'(w_push) - LW'(w_pop);
            if (w_push_req && w_full && !w_pop) begin
                ovf_d = 1'b1;
            end
        end
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            soft_q  <= soft_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q] <= bus_q;
        end
    end

    assign bus.cmd_valid  = valid_q;
    assign bus.cmd_meta   = valid_q ? mem_q[rd_q][22:18] : 5'd0;
    assign bus.cmd_data   = valid_q ? mem_q[rd_q][17:0]  : 18'd0;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
    assign bus.soft_rst   = soft_q;
endmodule
`default_nettype wire

// File: tb/tb_bus_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_receiver
// Description : Directed + randomized bench for bus_receiver. A queue-based
//               model of the command stream (NOOP absorbed, RST clears,
//               drop-when-full with sticky overflow) predicts every popped
//               word, the FIFO level and the overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_receiver;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_receiver_if #(.FIFO_DEPTH(DEPTH)) u_if ();

    bus_receiver #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int soft_cnt    = 0;
    int exp_soft    = 0;
    int max_level   = 0;
    logic [22:0] exp_q [$];
    logic        exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Effect of one received word on the abstract command queue.
    function automatic void model_word(input logic [4:0] m, input logic [17:0] d);
        if (m == 5'd0) return;
        if (m == 5'd31) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_soft++;
        end else if (exp_q.size() >= DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            exp_q.push_back({m, d});
        end
    endfunction

    // Observe the current cycle (from a negedge), then advance one cycle.
    task automatic tick();
        logic [22:0] w;
        if (u_if.soft_rst === 1'b1) soft_cnt++;
        if (int'(u_if.fifo_level) > max_level) max_level = int'(u_if.fifo_level);
        if (u_if.cmd_valid === 1'b1 && u_if.cmd_ready === 1'b1) begin
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 23'bx;
            chk("pop_meta", 32'(u_if.cmd_meta), 32'(w[22:18]));
            chk("pop_data", 32'(u_if.cmd_data), 32'(w[17:0]));
        end else if (u_if.cmd_valid === 1'b0) begin
            chk("idle_zero", {9'd0, u_if.cmd_meta, u_if.cmd_data}, 32'd0);
        end
        @(negedge clk);
    endtask

    // One master strobe period: data set 1 clk before the rise, strobe
    // high for hi clk, low for lo clk in total.
    task automatic send(input logic [4:0] m, input logic [17:0] d,
                        input int hi, input int lo, input bit pop_at_write);
        u_if.master_bus = {1'b0, m, d};
        tick();
        u_if.master_bus[23] = 1'b1;
        if (!pop_at_write) begin
            model_word(m, d);
            repeat (hi) tick();
        end else begin
            tick();
            tick();
            u_if.cmd_ready = 1'b1;   // accepting edge coincides with the write
            tick();
            u_if.cmd_ready = 1'b0;
            model_word(m, d);
            repeat (hi - 3) tick();
        end
        u_if.master_bus[23] = 1'b0;
        repeat (lo - 1) tick();
    endtask

    task automatic drain();
        u_if.cmd_ready = 1'b1;
        for (int i = 0; i < 64 && u_if.cmd_valid === 1'b1; i++) tick();
        u_if.cmd_ready = 1'b0;
        tick();
        chk("drain_level", 32'(u_if.fifo_level), 32'd0);
        chk("drain_model_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_level"}, 32'(u_if.fifo_level), 32'(exp_q.size()));
        chk({tag, "_ovf"},   32'(u_if.overflow),   32'(exp_ovf));
        chk({tag, "_valid"}, 32'(u_if.cmd_valid),  32'(exp_q.size() != 0));
    endtask

    function automatic logic [4:0] rand_data_meta();
        return 5'($urandom_range(1, 30));
    endfunction

    initial begin
        rst_n           = 1'b0;
        u_if.master_bus = '0;
        u_if.cmd_ready  = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(u_if.cmd_valid), 32'd0);
        chk("rst_level", 32'(u_if.fifo_level), 32'd0);
        chk("rst_ovf",   32'(u_if.overflow), 32'd0);
        chk("rst_soft",  32'(u_if.soft_rst), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // Single DATA word with cycle-exact latency.
        u_if.master_bus = {1'b0, 5'b00111, 18'h12345};
        tick();
        u_if.master_bus[23] = 1'b1;
        model_word(5'b00111, 18'h12345);
        tick();
        chk("lat_E0_valid", 32'(u_if.cmd_valid), 32'd0);
        tick();
        chk("lat_E1_valid", 32'(u_if.cmd_valid), 32'd0);
        tick();
        chk("lat_E2_valid", 32'(u_if.cmd_valid), 32'd1);
        chk("single_meta",  32'(u_if.cmd_meta), 32'h07);
        chk("single_data",  32'(u_if.cmd_data), 32'h12345);
        chk("single_level", 32'(u_if.fifo_level), 32'd1);
        repeat (2) tick();
        u_if.master_bus[23] = 1'b0;
        repeat (4) tick();
        u_if.cmd_ready = 1'b1;
        tick();
        u_if.cmd_ready = 1'b0;
        chk("single_pop_valid", 32'(u_if.cmd_valid), 32'd0);
        chk("single_pop_level", 32'(u_if.fifo_level), 32'd0);

        // Overflow: nine words into an eight-entry queue.
        for (int i = 1; i <= 9; i++) send(rand_data_meta(), 18'(i), 5, 5, 1'b0);
        chk_state("ovf");
        chk("ovf_level_full", 32'(u_if.fifo_level), 32'd8);
        chk("ovf_flag", 32'(u_if.overflow), 32'd1);
        drain();
        chk("ovf_sticky", 32'(u_if.overflow), 32'd1);

        // NOOP absorbed, RST flushes and clears overflow.
        for (int i = 0; i < 3; i++) send(rand_data_meta(), 18'($urandom), 5, 5, 1'b0);
        send(5'b00000, 18'($urandom), 5, 5, 1'b0);
        chk("noop_level", 32'(u_if.fifo_level), 32'd3);
        soft_cnt = 0;
        send(5'b11111, 18'($urandom), 5, 5, 1'b0);
        repeat (3) tick();
        chk("rst_word_soft_cnt", 32'(soft_cnt), 32'd1);
        chk_state("rst_word");
        chk("rst_word_level", 32'(u_if.fifo_level), 32'd0);

        // Full FIFO with a pop on the write cycle.
        for (int i = 0; i < DEPTH; i++) send(rand_data_meta(), 18'($urandom), 5, 5, 1'b0);
        chk("full_level", 32'(u_if.fifo_level), 32'd8);
        send(rand_data_meta(), 18'($urandom), 5, 5, 1'b1);
        chk_state("full_pop");
        chk("full_pop_level", 32'(u_if.fifo_level), 32'd8);
        drain();

        // Randomized mix including NOOP, RST and overflow.
        soft_cnt = 0;
        exp_soft = 0;
        for (int i = 0; i < 24; i++) begin
            logic [4:0] m;
            case ($urandom_range(0, 7))
                0:       m = 5'd0;
                1:       m = 5'd31;
                default: m = rand_data_meta();
            endcase
            send(m, 18'($urandom), 5, 5, 1'b0);
            chk_state("mix");
        end
        drain();
        chk("mix_soft_pulses", 32'(soft_cnt), 32'(exp_soft));

        // Clear the sticky flag, then a back-to-back stream at minimum period.
        send(5'b11111, 18'd0, 5, 5, 1'b0);
        max_level = 0;
        u_if.cmd_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(rand_data_meta(), 18'($urandom), 4, 4, 1'b0);
        drain();
        chk("b2b_ovf", 32'(u_if.overflow), 32'd0);
        chk("b2b_max_level_le1", 32'(max_level <= 1), 32'd1);

        // Asynchronous reset mid-stream, strobe held high through release.
        for (int i = 0; i < 3; i++) send(rand_data_meta(), 18'($urandom), 5, 5, 1'b0);
        chk("pre_arst_level", 32'(u_if.fifo_level), 32'd3);
        u_if.master_bus = {1'b1, 5'b00101, 18'h3C3C3};
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(u_if.cmd_valid), 32'd0);
        chk("arst_level", 32'(u_if.fifo_level), 32'd0);
        chk("arst_ovf",   32'(u_if.overflow), 32'd0);
        chk("arst_soft",  32'(u_if.soft_rst), 32'd0);
        chk("arst_bus",   {9'd0, u_if.cmd_meta, u_if.cmd_data}, 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk_state("held_high");
        u_if.master_bus[23] = 1'b0;
        repeat (6) tick();
        chk_state("after_low");
        send(5'b00011, 18'h00AAA, 5, 5, 1'b0);
        chk_state("post_arst");
        chk("post_arst_data", 32'(u_if.cmd_data), 32'h00AAA);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL timeout: simulation did not complete");
    end
endmodule
`default_nettype wire
